rc_channel_filter: RTL and testbench

Multi-channel successor to the single-channel throttle smoother. Sits between the receiver decoder and the angle/rate controllers: on each start request it latches all receiver channels, clamps each one, runs it through a DEPTH-deep moving average kept as a running sum, optionally applies the throttle piecewise-linear curve per channel, and publishes all results atomically with a one-cycle completion pulse.

---
 rtl/rc_channel_filter.sv | 182 ++++++++++++++++++
 tb/tb_rc_channel_filter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rc_channel_filter.sv
// Multi-channel receiver filter: snapshot, clamp, moving average (running sum),
// optional throttle curve per channel, atomic publish with a completion pulse.
module rc_channel_filter #(
    parameter int                  CHANNELS   = 4,
    parameter int                  WIDTH      = 8,
    parameter int                  DEPTH      = 8,
    parameter logic [CHANNELS-1:0] SCALE_MASK = 4'b0001,
    parameter int                  CLAMP_LOW  = 10,
    parameter int                  CLAMP_HIGH = 250
) (
    input  logic                      us_clk,
    input  logic                      resetn,
    input  logic                      start_signal,
    input  logic [CHANNELS*WIDTH-1:0] values_in,
    output logic [CHANNELS*WIDTH-1:0] values_out,
    output logic                      active_signal,
    output logic                      complete_signal
);
    localparam int LOG2  = $clog2(DEPTH);
    localparam int SUM_W = WIDTH + LOG2;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int EW    = WIDTH + 2;

    localparam logic [WIDTH-1:0] LOW     = WIDTH'(CLAMP_LOW);
    localparam logic [WIDTH-1:0] HIGH    = WIDTH'(CLAMP_HIGH);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic [EW-1:0]    K42     = EW'(42);
    localparam logic [EW-1:0]    K209    = EW'(209);
    localparam logic [EW-1:0]    K252    = EW'(252);
    localparam logic [EW-1:0]    K61     = EW'(61);

    typedef enum logic [2:0] {
        S_WAIT, S_LATCH, S_UPDATE, S_AVERAGE, S_SCALE, S_COMPLETE
    } state_t;

    state_t                    r_state;
    logic [CH_W-1:0]           r_ch;
    logic [LOG2-1:0]           r_ptr;
    logic                      r_pending;
    logic                      r_start_d;
    logic [CHANNELS*WIDTH-1:0] r_snap;
    logic [WIDTH-1:0]          r_v;
    logic                      r_flush;
    logic [WIDTH-1:0]          r_avg;
    logic                      r_active;
    logic                      r_complete;

    logic [CHANNELS*SUM_W-1:0] w_sums;
    logic [CHANNELS*WIDTH-1:0] w_out_next;
    logic [SUM_W-1:0]          w_sum_sel;
    logic [WIDTH-1:0]          w_snap_sel;
    logic [EW-1:0]             w_avg_ext;
    logic [EW-1:0]             w_curve;
    logic [WIDTH-1:0]          w_scaled;
    logic [WIDTH-1:0]          w_result;
    logic                      w_rise;

    assign w_rise          = start_signal & ~r_start_d;
    assign active_signal   = r_active;
    assign complete_signal = r_complete;

    always_comb begin
        w_sum_sel  = '0;
        w_snap_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_ch == CH_W'(i)) begin
                w_sum_sel  = w_sums[i*SUM_W +: SUM_W];
                w_snap_sel = r_snap[i*WIDTH +: WIDTH];
            end
        end
    end

    // Throttle curve: steep near idle and full, gentle through the middle.
    always_comb begin
        w_avg_ext = {2'b00, r_avg};
        w_curve   = (w_avg_ext >> 1) + K61;
        if (w_avg_ext < K42) begin
            w_curve = w_avg_ext << 1;
        end else if (w_avg_ext > K209) begin
            w_curve = (w_avg_ext << 1) - K252;
        end
        w_scaled = (|w_curve[EW-1:WIDTH]) ? '1 : w_curve[WIDTH-1:0];
        w_result = SCALE_MASK[r_ch] ? w_scaled : r_avg;
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] r_buf [DEPTH];
            logic [SUM_W-1:0] r_sum;
            logic [WIDTH-1:0] r_shadow;

            always_ff @(posedge us_clk or negedge resetn) begin
                if (!resetn) begin
                    r_sum    <= '0;
                    r_shadow <= '0;
                    for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
                end else if (r_ch == CH_W'(gi)) begin
                    if (r_state == S_UPDATE) begin
                        if (r_flush) begin
                            r_sum <= '0;
                            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
                        end else begin
                            // Oldest entry is already part of the sum, so this never underflows.
                            r_sum        <= r_sum - SUM_W'(r_buf[r_ptr]) + SUM_W'(r_v);
                            r_buf[r_ptr] <= r_v;
                        end
                    end
                    if (r_state == S_SCALE) r_shadow <= w_result;
                end
            end

            assign w_sums[gi*SUM_W +: SUM_W]     = r_sum;
            assign w_out_next[gi*WIDTH +: WIDTH] = (r_ch == CH_W'(gi)) ? w_result : r_shadow;
        end
    endgenerate

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_WAIT;
            r_ch       <= '0;
            r_ptr      <= '0;
            r_pending  <= 1'b0;
            r_start_d  <= 1'b0;
            r_snap     <= '0;
            r_v        <= '0;
            r_flush    <= 1'b0;
            r_avg      <= '0;
            r_active   <= 1'b0;
            r_complete <= 1'b0;
            values_out <= '0;
        end else begin
            r_start_d  <= start_signal;
            r_complete <= 1'b0;
            if (r_state != S_WAIT && w_rise) r_pending <= 1'b1;

            case (r_state)
                S_WAIT: begin
                    if (r_pending || start_signal) begin
                        r_pending <= 1'b0;
                        r_snap    <= values_in;
                        r_ch      <= '0;
                        r_active  <= 1'b1;
                        r_state   <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_flush <= 1'b0;
                    if (w_snap_sel < LOW) begin
                        r_v     <= '0;
                        r_flush <= 1'b1;
                    end else if (w_snap_sel > HIGH) begin
                        r_v <= HIGH;
                    end else begin
                        r_v <= w_snap_sel;
                    end
                    r_state <= S_UPDATE;
                end
                S_UPDATE: r_state <= S_AVERAGE;
                S_AVERAGE: begin
                    r_avg   <= w_sum_sel[SUM_W-1:LOG2];
                    r_state <= S_SCALE;
                end
                S_SCALE: begin
                    if (r_ch == LAST_CH) begin
                        values_out <= w_out_next;
                        r_active   <= 1'b0;
                        r_complete <= 1'b1;
                        r_state    <= S_COMPLETE;
                    end else begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_state <= S_LATCH;
                    end
                end
                S_COMPLETE: begin
                    r_ptr   <= r_ptr + LOG2'(1);
                    r_state <= S_WAIT;
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_rc_channel_filter.sv
// Directed bench for rc_channel_filter: ramp, clamp/flush, pending requests,
// snapshot isolation and mid-frame reset.
module tb_rc_channel_filter;
    logic        us_clk        = 1'b0;
    logic        resetn        = 1'b1;
    logic        start_signal  = 1'b0;
    logic [31:0] values_in     = '0;
    logic [31:0] values_out;
    logic        active_signal;
    logic        complete_signal;

    int n_cmp = 0;
    int n_err = 0;

    rc_channel_filter dut (
        .us_clk          (us_clk),
        .resetn          (resetn),
        .start_signal    (start_signal),
        .values_in       (values_in),
        .values_out      (values_out),
        .active_signal   (active_signal),
        .complete_signal (complete_signal)
    );

    always #5 us_clk = ~us_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Enter and leave on a negedge with the DUT idle in WAIT.
    task automatic run_frame(input logic [31:0] vin, input logic [31:0] exp, input string tag);
        int cyc;
        values_in    = vin;
        start_signal = 1'b1;
        @(negedge us_clk);
        start_signal = 1'b0;
        cyc = 1;
        check({tag, "_active"}, 32'(active_signal), 32'd1);
        while (!complete_signal && cyc < 40) begin
            @(negedge us_clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd17);
        check({tag, "_out"}, values_out, exp);
        check({tag, "_active_low"}, 32'(active_signal), 32'd0);
        @(negedge us_clk);
        check({tag, "_pulse_1cyc"}, 32'(complete_signal), 32'd0);
        $display("frame %s: in=%h out=%h exp=%h latency=%0d", tag, vin, values_out, exp, cyc);
    endtask

    // Packed {ch3, ch2, ch1, ch0}; ch0 uses the throttle curve, others pass through.
    logic [31:0] base_in = {8'd200, 8'd30, 8'd100, 8'd100};
    logic [31:0] ramp_exp [8] = '{
        {8'd25,  8'd3,  8'd12,  8'd24},
        {8'd50,  8'd7,  8'd25,  8'd50},
        {8'd75,  8'd11, 8'd37,  8'd74},
        {8'd100, 8'd15, 8'd50,  8'd86},
        {8'd125, 8'd18, 8'd62,  8'd92},
        {8'd150, 8'd22, 8'd75,  8'd98},
        {8'd175, 8'd26, 8'd87,  8'd104},
        {8'd200, 8'd30, 8'd100, 8'd111}
    };
    // ch0 stepping from a full buffer of 100 towards a clamped 250.
    logic [7:0] clamp_exp [8] = '{8'd120, 8'd129, 8'd139, 8'd148, 8'd157, 8'd172, 8'd210, 8'd248};

    initial begin
        int any_high;
        int ncomp;
        int first_t;
        int second_t;
        int cyc;

        // Reset and idle
        #2 resetn = 1'b0;
        @(negedge us_clk);
        @(negedge us_clk);
        resetn = 1'b1;
        check("rst_out", values_out, 32'd0);
        check("rst_active", 32'(active_signal), 32'd0);
        check("rst_complete", 32'(complete_signal), 32'd0);
        any_high = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge us_clk);
            if (active_signal || complete_signal) any_high = 1;
        end
        check("idle_quiet", 32'(any_high), 32'd0);

        // Warm-up ramp over DEPTH frames, then steady state
        for (int f = 0; f < 9; f++) begin
            run_frame(base_in, ramp_exp[(f < 8) ? f : 7], $sformatf("ramp%0d", f + 1));
        end

        // Over-range ch0 clamps to 250
        for (int f = 0; f < 8; f++) begin
            run_frame({base_in[31:8], 8'd255}, {8'd200, 8'd30, 8'd100, clamp_exp[f]},
                      $sformatf("clamp%0d", f + 1));
        end

        // Idle cut flushes ch0, then it restarts from an empty buffer
        run_frame({base_in[31:8], 8'd5},   {8'd200, 8'd30, 8'd100, 8'd0},  "flush");
        run_frame({base_in[31:8], 8'd200}, {8'd200, 8'd30, 8'd100, 8'd50}, "after_flush");

        // Two start pulses during a busy frame give exactly one extra frame
        ncomp    = 0;
        first_t  = -1;
        second_t = -1;
        for (int t = 0; t < 60; t++) begin
            start_signal = (t == 0 || t == 3 || t == 6);
            @(negedge us_clk);
            if (complete_signal) begin
                ncomp++;
                if (first_t < 0) first_t = t;
                else second_t = t;
            end
        end
        start_signal = 1'b0;
        check("pending_count", 32'(ncomp), 32'd2);
        check("pending_gap_ge17", 32'((second_t - first_t) >= 17), 32'd1);
        $display("pending: completes=%0d at t=%0d and t=%0d", ncomp, first_t, second_t);

        // Reset at frame cycle 7 aborts without touching values_out
        values_in    = base_in;
        start_signal = 1'b1;
        @(negedge us_clk);
        start_signal = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge us_clk);
        resetn = 1'b0;
        #1;
        check("midrst_out", values_out, 32'd0);
        check("midrst_active", 32'(active_signal), 32'd0);
        @(negedge us_clk);
        resetn = 1'b1;
        any_high = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge us_clk);
            if (active_signal || complete_signal) any_high = 1;
        end
        check("midrst_wait", 32'(any_high), 32'd0);
        check("midrst_out_hold", values_out, 32'd0);
        $display("mid-frame reset: out=%h active=%0d", values_out, active_signal);

        // Averages rebuild from zero after reset
        run_frame(base_in, ramp_exp[0], "restart1");

        // values_in scribbled during cycles 2..10 must not leak into the frame
        values_in    = base_in;
        start_signal = 1'b1;
        @(negedge us_clk);
        start_signal = 1'b0;
        cyc = 1;
        while (!complete_signal && cyc < 40) begin
            values_in = (cyc >= 2 && cyc <= 10) ? 32'h0505_FFFF : base_in;
            @(negedge us_clk);
            cyc++;
        end
        values_in = base_in;
        check("snap_latency", 32'(cyc), 32'd17);
        check("snap_out", values_out, ramp_exp[1]);
        $display("snapshot frame: out=%h exp=%h", values_out, ramp_exp[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
